// File: rtl/stopwatch_timer_datapath_if.sv
// stopwatch_timer_datapath_if: strobes from the control FSM and the datapath's returned status/display bus.
interface stopwatch_timer_datapath_if #(
  parameter int W     = 16,
  parameter int DEPTH = 4
);
  logic                     clear;
  logic                     enable;
  logic                     read;
  logic                     write;
  logic                     enable_increment;
  logic                     enable_decrement;
  logic                     step;
  logic [1:0]               output_select;
  logic                     flag;
  logic [W-1:0]             display;
  logic [$clog2(DEPTH):0]   lap_count;
  modport master (
    output clear, enable, read, write, enable_increment, enable_decrement, step, output_select,
    input  flag, display, lap_count
  );
  modport slave (
    input  clear, enable, read, write, enable_increment, enable_decrement, step, output_select,
    output flag, display, lap_count
  );
endinterface

// File: rtl/stopwatch_timer_datapath.sv
// stopwatch_timer_datapath: stopwatch, circular lap buffer and countdown timer with a display mux.
module stopwatch_timer_datapath #(
  parameter int W        = 16,
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 100000,
  parameter int STEP     = 100
) (
  input logic                       clk,
  input logic                       nrst,
  stopwatch_timer_datapath_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  sw_q, sw_d, tmr_q, tmr_d;
  logic          flag_q, flag_d, read_q, write_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_addr, last_addr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  lap_q [DEPTH];
  logic [W:0]    sum;
  logic          tick, wr_rise, rd_rise, inc, dec;
  assign tick    = pre_q == PW'(TICK_DIV - 1);
  assign wr_rise = bus.write & ~write_q;
  assign rd_rise = bus.read & ~read_q;
  assign inc     = bus.step & bus.enable_increment;
  // a step press takes precedence over a coincident countdown tick
  assign dec     = bus.enable_decrement & tick & (tmr_q != '0) & ~inc;
  assign sum     = {1'b0, tmr_q} + (W+1)'(STEP);
  always_comb begin
    pre_d  = (bus.clear | tick) ? '0 : pre_q + 1'b1;
    sw_d   = bus.clear ? '0 : (bus.enable & tick & ~&sw_q) ? sw_q + 1'b1 : sw_q;
    tmr_d  = bus.clear ? '0 : inc ? (sum[W] ? '1 : sum[W-1:0]) : dec ? tmr_q - 1'b1 : tmr_q;
    flag_d = ~bus.clear & (flag_q | (dec & (tmr_q == W'(1))) | (bus.enable_decrement & (tmr_q == '0)));
    wr_d   = bus.clear ? '0 : wr_rise ? wr_q + 1'b1 : wr_q;
    cnt_d  = bus.clear ? '0 : (wr_rise & (cnt_q != CW'(DEPTH))) ? cnt_q + 1'b1 : cnt_q;
    // wrap test uses the pre-write count so a simultaneous capture does not extend this pass
    rd_d   = (bus.clear | (cnt_q == '0)) ? '0 :
             rd_rise ? ((CW'(rd_q) == cnt_q - 1'b1) ? '0 : rd_q + 1'b1) : rd_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pre_q   <= '0;
      sw_q    <= '0;
      tmr_q   <= '0;
      flag_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) lap_q[i] <= '0;
    end else begin
      pre_q   <= pre_d;
      sw_q    <= sw_d;
      tmr_q   <= tmr_d;
      flag_q  <= flag_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      read_q  <= bus.read;
      write_q <= bus.write;
      if (wr_rise & ~bus.clear) lap_q[wr_q] <= sw_q;
    end
  end
  // entry 0 of the read order is the oldest valid lap
  assign rd_addr   = wr_q - cnt_q[AW-1:0] + rd_q;
  assign last_addr = wr_q - 1'b1;
  assign bus.display = (bus.output_select == 2'd0) ? tmr_q :
                       (bus.output_select == 2'd1) ? sw_q :
                       (cnt_q == '0) ? '0 :
                       bus.output_select[0] ? lap_q[last_addr] : lap_q[rd_addr];
  assign bus.flag      = flag_q;
  assign bus.lap_count = cnt_q;
endmodule

// File: tb/tb_stopwatch_timer_datapath.sv
// tb_stopwatch_timer_datapath: directed stimulus checked every cycle against a queue-based behavioural model.
module tb_stopwatch_timer_datapath;
  localparam int W = 8, DEPTH = 4, TD = 4, STP = 3, MAX = 255;
  logic clk = 1'b0, nrst = 1'b0;
  int n_cmp = 0, n_bad = 0;
  stopwatch_timer_datapath_if #(.W(W), .DEPTH(DEPTH)) bus ();
  stopwatch_timer_datapath #(.W(W), .DEPTH(DEPTH), .TICK_DIV(TD), .STEP(STP)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );
  always #5 clk = ~clk;
  int m_pre, m_sw, m_tmr, m_flag, m_rd, m_pw, m_pr;
  int laps[$];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int m_disp(input logic [1:0] sel);
    if (sel == 2'd0) return m_tmr;
    if (sel == 2'd1) return m_sw;
    if (laps.size() == 0) return 0;
    return (sel == 2'd2) ? laps[m_rd] : laps[laps.size()-1];
  endfunction
  always @(posedge clk or negedge nrst) begin : model
    bit tick, wrise, rrise;
    int t0;
    if (!nrst) begin
      m_pre = 0; m_sw = 0; m_tmr = 0; m_flag = 0; m_rd = 0; m_pw = 0; m_pr = 0;
      laps.delete();
    end else begin
      tick  = (m_pre == TD - 1);
      wrise = bus.write && !m_pw;
      rrise = bus.read && !m_pr;
      if (bus.clear) begin
        m_pre = 0; m_sw = 0; m_tmr = 0; m_flag = 0; m_rd = 0;
        laps.delete();
      end else begin
        m_pre = (m_pre + 1) % TD;
        if (rrise && laps.size() > 0) m_rd = (m_rd + 1) % laps.size();
        if (wrise) begin
          laps.push_back(m_sw);
          if (laps.size() > DEPTH) void'(laps.pop_front());
        end
        if (bus.enable && tick && m_sw < MAX) m_sw++;
        t0 = m_tmr;
        if (bus.step && bus.enable_increment) m_tmr = (t0 + STP > MAX) ? MAX : t0 + STP;
        else if (bus.enable_decrement && tick && t0 > 0) begin
          if (t0 == 1) m_flag = 1;
          m_tmr = t0 - 1;
        end
        if (bus.enable_decrement && t0 == 0) m_flag = 1;
      end
      m_pw = bus.write;
      m_pr = bus.read;
    end
  end
  always @(negedge clk) begin
    chk("model_display", int'(bus.display), m_disp(bus.output_select));
    chk("model_flag", int'(bus.flag), m_flag);
    chk("model_lap_count", int'(bus.lap_count), laps.size());
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_clear();
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
  endtask
  task automatic run_to(input int v);
    int n = 0;
    bus.enable = 1'b1;
    while (int'(bus.display) != v && n < 1200) begin
      cyc(1);
      n++;
    end
    bus.enable = 1'b0;
    chk("run_to", int'(bus.display), v);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int exp_rd[4] = '{3, 4, 5, 2};
    bus.clear = 0; bus.enable = 0; bus.read = 0; bus.write = 0;
    bus.enable_increment = 0; bus.enable_decrement = 0; bus.step = 0; bus.output_select = 2'd0;
    cyc(2);
    chk("reset_display", int'(bus.display), 0);
    chk("reset_flag", int'(bus.flag), 0);
    chk("reset_lap_count", int'(bus.lap_count), 0);
    nrst = 1'b1;
    bus.enable = 1'b1;
    bus.output_select = 2'd1;
    cyc(40);
    bus.enable = 1'b0;
    chk("sw_40cyc", int'(bus.display), 10);
    cyc(3);
    chk("sw_hold", int'(bus.display), 10);
    pulse_clear();
    chk("sw_clear", int'(bus.display), 0);
    run_to(5);
    bus.write = 1'b1;
    cyc(3);
    bus.write = 1'b0;
    cyc(1);
    chk("single_capture", int'(bus.lap_count), 1);
    bus.output_select = 2'd3;
    #1;
    chk("last_lap", int'(bus.display), 5);
    pulse_clear();
    bus.output_select = 2'd1;
    for (int v = 1; v <= 5; v++) begin
      run_to(v);
      bus.write = 1'b1;
      cyc(1);
      bus.write = 1'b0;
      cyc(1);
    end
    chk("laps_full", int'(bus.lap_count), 4);
    bus.output_select = 2'd2;
    #1;
    chk("lap_oldest", int'(bus.display), 2);
    for (int i = 0; i < 4; i++) begin
      bus.read = 1'b1;
      cyc(1);
      bus.read = 1'b0;
      cyc(1);
      chk("lap_read", int'(bus.display), exp_rd[i]);
    end
    pulse_clear();
    bus.output_select = 2'd0;
    bus.enable_increment = 1'b1;
    repeat (3) begin
      bus.step = 1'b1;
      cyc(1);
      bus.step = 1'b0;
      cyc(1);
    end
    bus.enable_increment = 1'b0;
    chk("timer_set", int'(bus.display), 9);
    chk("flag_idle", int'(bus.flag), 0);
    cyc(2);
    bus.enable_decrement = 1'b1;
    n = 0;
    while (bus.display != '0 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("countdown_cycles", n, 36);
    cyc(1);
    chk("flag_set", int'(bus.flag), 1);
    cyc(5);
    chk("flag_sticky", int'(bus.flag), 1);
    bus.enable_decrement = 1'b0;
    pulse_clear();
    chk("flag_cleared", int'(bus.flag), 0);
    bus.enable_decrement = 1'b1;
    #1;
    chk("flag_zero_pre", int'(bus.flag), 0);
    cyc(1);
    chk("flag_zero_start", int'(bus.flag), 1);
    bus.enable_decrement = 1'b0;
    bus.enable_increment = 1'b1;
    pulse_clear();
    bus.step = 1'b1; cyc(1);
    bus.step = 1'b0; cyc(1);
    bus.step = 1'b1; cyc(1);
    chk("timer_6", int'(bus.display), 6);
    bus.enable_decrement = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    chk("step_beats_tick", int'(bus.display), 9);
    cyc(4);
    chk("tick_after_step", int'(bus.display), 8);
    bus.enable_decrement = 1'b0;
    bus.enable_increment = 1'b0;
    pulse_clear();
    bus.output_select = 2'd1;
    run_to(255);
    bus.enable = 1'b1;
    cyc(8);
    chk("sw_saturate", int'(bus.display), 255);
    bus.enable = 1'b0;
    bus.enable_increment = 1'b1;
    repeat (90) begin
      bus.step = 1'b1;
      cyc(1);
      bus.step = 1'b0;
      cyc(1);
    end
    bus.enable_increment = 1'b0;
    bus.output_select = 2'd0;
    #1;
    chk("timer_saturate", int'(bus.display), 255);
    bus.write = 1'b1;
    cyc(1);
    bus.write = 1'b0;
    cyc(1);
    chk("pre_reset_laps", int'(bus.lap_count), 1);
    bus.enable = 1'b1;
    bus.output_select = 2'd1;
    cyc(2);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_sw", int'(bus.display), 0);
    chk("async_laps", int'(bus.lap_count), 0);
    bus.output_select = 2'd0;
    #1;
    chk("async_timer", int'(bus.display), 0);
    bus.output_select = 2'd3;
    #1;
    chk("async_last_lap", int'(bus.display), 0);
    cyc(2);
    nrst = 1'b1;
    bus.enable = 1'b0;
    cyc(2);
    chk("post_reset_laps", int'(bus.lap_count), 0);
    chk("post_reset_flag", int'(bus.flag), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
